// File: rtl/icache_refill_ctrl_pkg.sv
// Shared encodings for the I-cache refill controller: FSM states, AXI burst
// fields and the byte-within-word width of the 32-bit fetch path.
package icache_refill_ctrl_pkg;

  localparam int BYTE_BITS = 2;  // 4-byte words

  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DATA   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // AXI arlen for a burst that fills one cache line
  function automatic logic [7:0] line_arlen(input int offset_bits);
    return 8'((1 << offset_bits) - 1);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill: one AXI4 INCR read burst per miss, beats streamed into
// the data array, critical word forwarded on arrival, tag committed at the end.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               miss_req,
  input  logic [ADDR_WIDTH-1:0]                              miss_addr,
  output logic                                               miss_ready,
  output logic                                               m_arvalid,
  input  logic                                               m_arready,
  output logic [ADDR_WIDTH-1:0]                              m_araddr,
  output logic [7:0]                                         m_arlen,
  output logic [2:0]                                         m_arsize,
  output logic [1:0]                                         m_arburst,
  input  logic                                               m_rvalid,
  output logic                                               m_rready,
  input  logic [31:0]                                        m_rdata,
  input  logic [1:0]                                         m_rresp,
  input  logic                                               m_rlast,
  output logic                                               da_we,
  output logic [INDEX_BITS-1:0]                              da_index,
  output logic [OFFSET_BITS-1:0]                             da_offset,
  output logic [31:0]                                        da_wdata,
  output logic                                               tag_we,
  output logic [INDEX_BITS-1:0]                              tag_index,
  output logic [ADDR_WIDTH-INDEX_BITS-OFFSET_BITS-BYTE_BITS-1:0] tag_value,
  output logic                                               tag_valid,
  output logic                                               fwd_valid,
  output logic [31:0]                                        fwd_data,
  output logic                                               refill_done,
  output logic                                               refill_error
);

  localparam int LINE_LSB = OFFSET_BITS + BYTE_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - LINE_LSB;

  state_e                 state_reg, state_next;
  logic [OFFSET_BITS-1:0] cnt_reg, cnt_next;
  logic                   err_reg, err_next;
  logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
  logic                   beat;
  logic                   last_beat;
  logic                   crit_hit;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^addr_reg[BYTE_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
    end
  end

  assign beat      = (state_reg == ST_DATA) && m_rvalid;
  assign last_beat = (cnt_reg == '1);
  assign crit_hit  = (cnt_reg == addr_reg[BYTE_BITS +: OFFSET_BITS]) && (m_rresp == AXI_RESP_OKAY);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    addr_next    = addr_reg;
    miss_ready   = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    tag_we       = 1'b0;
    tag_valid    = 1'b0;
    refill_done  = 1'b0;
    refill_error = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        miss_ready = 1'b1;
        if (miss_req) begin
          addr_next  = miss_addr;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_next = ST_DATA;
      end
      ST_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          cnt_next = cnt_reg + 1'b1;
          // a late, early or missing rlast poisons the line but the beat count still ends the burst
          if ((m_rresp != AXI_RESP_OKAY) || (m_rlast != last_beat)) err_next = 1'b1;
          if (last_beat) state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        refill_done  = 1'b1;
        refill_error = err_reg;
        tag_we       = !err_reg;
        tag_valid    = !err_reg;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign m_araddr  = {addr_reg[ADDR_WIDTH-1:LINE_LSB], {LINE_LSB{1'b0}}};
  assign m_arlen   = line_arlen(OFFSET_BITS);
  assign m_arsize  = AXI_SIZE_WORD;
  assign m_arburst = AXI_BURST_INCR;

  // errored beats are still written; the line stays invalid so they are never hit
  assign da_we     = beat;
  assign da_index  = addr_reg[LINE_LSB +: INDEX_BITS];
  assign da_offset = cnt_reg;
  assign da_wdata  = beat ? m_rdata : '0;

  assign fwd_valid = beat && crit_hit;
  assign fwd_data  = (beat && crit_hit) ? m_rdata : '0;

  assign tag_index = addr_reg[LINE_LSB +: INDEX_BITS];
  assign tag_value = addr_reg[ADDR_WIDTH-1 -: TAG_BITS];

endmodule
